// File: rtl/menshen_cfg_arbiter.sv
// menshen_cfg_arbiter: packet-granular arbiter sharing the H2C stream.
// Define MENSHEN_CFG_GAP_EN to add a hold-off gap after config packets.
module menshen_cfg_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_CTRL_BURST       = 4,
  parameter int CFG_GAP_CYCLES       = 30
) (
  input  logic                              axis_aclk,
  input  logic                              aresetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_ctrl_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_ctrl_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_ctrl_tuser,
  input  logic                              s_axis_ctrl_tvalid,
  input  logic                              s_axis_ctrl_tlast,
  output logic                              s_axis_ctrl_tready,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_data_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_data_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_data_tuser,
  input  logic                              s_axis_data_tvalid,
  input  logic                              s_axis_data_tlast,
  output logic                              s_axis_data_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  output logic [15:0]                       cfg_pkt_cnt,
  output logic                              busy
);

  localparam int BW = $clog2(MAX_CTRL_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CTRL_BURST);

  if (MAX_CTRL_BURST < 1) begin : g_bad_burst
    $error("MAX_CTRL_BURST must be at least 1");
  end

  if (CFG_GAP_CYCLES < 1) begin : g_bad_gap
    $error("CFG_GAP_CYCLES must be at least 1");
  end

`ifdef MENSHEN_CFG_GAP_EN
  localparam int GW = $clog2(CFG_GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CFG_GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2
  } state_t;
`endif

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] ctrl_burst;
  logic          ctrl_done;
  logic          data_done;
  logic          ctrl_wins;

  assign ctrl_done = (state == CTRL) && s_axis_ctrl_tvalid
                  && m_axis_tready && s_axis_ctrl_tlast;
  assign data_done = (state == DATA) && s_axis_data_tvalid
                  && m_axis_tready && s_axis_data_tlast;

  // Config has priority unless it has used up its burst while data waits
  assign ctrl_wins = s_axis_ctrl_tvalid
                  && ((ctrl_burst < BURST_MAX) || !s_axis_data_tvalid);

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  // Next state: grants only change on packet boundaries
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ctrl_wins)               state_n = CTRL;
        else if (s_axis_data_tvalid) state_n = DATA;
      end
      CTRL: begin
        if (ctrl_done) begin
`ifdef MENSHEN_CFG_GAP_EN
          state_n = GAP;
`else
          state_n = IDLE;
`endif
        end
      end
      DATA: begin
        if (data_done) state_n = IDLE;
      end
`ifdef MENSHEN_CFG_GAP_EN
      GAP: begin
        if (gap_cnt <= GW'(1)) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Output mux: granted source passes straight through, zeros otherwise
  always_comb begin
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tuser       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    s_axis_ctrl_tready = 1'b0;
    s_axis_data_tready = 1'b0;
    case (state)
      CTRL: begin
        m_axis_tdata       = s_axis_ctrl_tdata;
        m_axis_tkeep       = s_axis_ctrl_tkeep;
        m_axis_tuser       = s_axis_ctrl_tuser;
        m_axis_tvalid      = s_axis_ctrl_tvalid;
        m_axis_tlast       = s_axis_ctrl_tlast;
        s_axis_ctrl_tready = m_axis_tready;
      end
      DATA: begin
        m_axis_tdata       = s_axis_data_tdata;
        m_axis_tkeep       = s_axis_data_tkeep;
        m_axis_tuser       = s_axis_data_tuser;
        m_axis_tvalid      = s_axis_data_tvalid;
        m_axis_tlast       = s_axis_data_tlast;
        s_axis_data_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  // Burst tracking and forwarded config packet count
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_burst  <= '0;
      cfg_pkt_cnt <= '0;
    end else begin
      if (ctrl_done) begin
        cfg_pkt_cnt <= cfg_pkt_cnt + 16'd1;
        if (ctrl_burst != BURST_MAX) ctrl_burst <= ctrl_burst + 1'b1;
      end else if (data_done) begin
        ctrl_burst <= '0;
      end
    end
  end

`ifdef MENSHEN_CFG_GAP_EN
  // Hold-off counter: loaded at config tlast, counts down through GAP
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      gap_cnt <= '0;
    end else if (ctrl_done) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_menshen_cfg_arbiter.sv
// tb_menshen_cfg_arbiter: randomized scoreboard bench.
// Packet order comes from a queue-level model of the burst rule.
`timescale 1ns/1ps
module tb_menshen_cfg_arbiter;

  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int UW   = 128;
  localparam int MAXB = 4;
  localparam int GAP  = 30;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          first;
    logic          src;
  } beat_t;

  logic          clk;
  logic          aresetn;
  logic [DW-1:0] s_axis_ctrl_tdata;
  logic [KW-1:0] s_axis_ctrl_tkeep;
  logic [UW-1:0] s_axis_ctrl_tuser;
  logic          s_axis_ctrl_tvalid;
  logic          s_axis_ctrl_tlast;
  logic          s_axis_ctrl_tready;
  logic [DW-1:0] s_axis_data_tdata;
  logic [KW-1:0] s_axis_data_tkeep;
  logic [UW-1:0] s_axis_data_tuser;
  logic          s_axis_data_tvalid;
  logic          s_axis_data_tlast;
  logic          s_axis_data_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [15:0]   cfg_pkt_cnt;
  logic          busy;

  menshen_cfg_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .MAX_CTRL_BURST      (MAXB),
    .CFG_GAP_CYCLES      (GAP)
  ) dut (
    .axis_aclk         (clk),
    .aresetn           (aresetn),
    .s_axis_ctrl_tdata (s_axis_ctrl_tdata),
    .s_axis_ctrl_tkeep (s_axis_ctrl_tkeep),
    .s_axis_ctrl_tuser (s_axis_ctrl_tuser),
    .s_axis_ctrl_tvalid(s_axis_ctrl_tvalid),
    .s_axis_ctrl_tlast (s_axis_ctrl_tlast),
    .s_axis_ctrl_tready(s_axis_ctrl_tready),
    .s_axis_data_tdata (s_axis_data_tdata),
    .s_axis_data_tkeep (s_axis_data_tkeep),
    .s_axis_data_tuser (s_axis_data_tuser),
    .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast (s_axis_data_tlast),
    .s_axis_data_tready(s_axis_data_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .cfg_pkt_cnt       (cfg_pkt_cnt),
    .busy              (busy)
  );

  beat_t cq[$];
  beat_t dq[$];
  beat_t exq[$];

  int n_chk  = 0;
  int n_fail = 0;

  bit mon_en     = 1'b1;
  bit gap_chk_en = 1'b0;
  bit nobub      = 1'b0;
  int tmode      = 2;

  bit wait_first = 1'b0;
  int idle_cnt   = 0;
  int exp_idle   = 1;

  bit drv_cf;
  bit drv_df;
  bit tog;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic beat_t rnd_beat(bit src, bit first, bit last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    for (int i = 0; i < KW / 32; i++) b.keep[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW / 32; i++) b.user[i*32 +: 32] = $urandom;
    b.last  = last;
    b.first = first;
    b.src   = src;
    return b;
  endfunction

  // Create one packet on a source; optionally it is expected next in order
  task automatic gen_pkt(input bit src, input int len, input bit to_exp);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = rnd_beat(src, k == 0, k == len - 1);
      if (src) dq.push_back(b);
      else     cq.push_back(b);
      if (to_exp) exq.push_back(b);
    end
  endtask

  // Source and sink driver: head beat offered, popped after a handshake
  initial begin
    s_axis_ctrl_tdata  = '0;
    s_axis_ctrl_tkeep  = '0;
    s_axis_ctrl_tuser  = '0;
    s_axis_ctrl_tvalid = 1'b0;
    s_axis_ctrl_tlast  = 1'b0;
    s_axis_data_tdata  = '0;
    s_axis_data_tkeep  = '0;
    s_axis_data_tuser  = '0;
    s_axis_data_tvalid = 1'b0;
    s_axis_data_tlast  = 1'b0;
    m_axis_tready      = 1'b0;
    tog                = 1'b0;
    forever begin
      @(negedge clk);
      drv_cf = s_axis_ctrl_tvalid && s_axis_ctrl_tready;
      drv_df = s_axis_data_tvalid && s_axis_data_tready;
      @(posedge clk);
      #1;
      if (aresetn) begin
        if (drv_cf && cq.size() > 0) void'(cq.pop_front());
        if (drv_df && dq.size() > 0) void'(dq.pop_front());
      end
      if (cq.size() > 0 && (cq[0].first || nobub
                            || $urandom_range(3) != 0)) begin
        s_axis_ctrl_tdata  = cq[0].data;
        s_axis_ctrl_tkeep  = cq[0].keep;
        s_axis_ctrl_tuser  = cq[0].user;
        s_axis_ctrl_tlast  = cq[0].last;
        s_axis_ctrl_tvalid = 1'b1;
      end else begin
        s_axis_ctrl_tdata  = '0;
        s_axis_ctrl_tkeep  = '0;
        s_axis_ctrl_tuser  = '0;
        s_axis_ctrl_tlast  = 1'b0;
        s_axis_ctrl_tvalid = 1'b0;
      end
      if (dq.size() > 0 && (dq[0].first || nobub
                            || $urandom_range(3) != 0)) begin
        s_axis_data_tdata  = dq[0].data;
        s_axis_data_tkeep  = dq[0].keep;
        s_axis_data_tuser  = dq[0].user;
        s_axis_data_tlast  = dq[0].last;
        s_axis_data_tvalid = 1'b1;
      end else begin
        s_axis_data_tdata  = '0;
        s_axis_data_tkeep  = '0;
        s_axis_data_tuser  = '0;
        s_axis_data_tlast  = 1'b0;
        s_axis_data_tvalid = 1'b0;
      end
      case (tmode)
        0:       m_axis_tready = 1'($urandom_range(1));
        1: begin tog = ~tog; m_axis_tready = tog; end
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every output beat and inter-packet idle spacing
  always @(negedge clk) begin
    if (!aresetn) begin
      wait_first <= 1'b0;
      idle_cnt   <= 0;
    end else if (mon_en) begin
      if (wait_first) begin
        if (!m_axis_tvalid) begin
          idle_cnt <= idle_cnt + 1;
        end else begin
          chk("idle_between_pkts", idle_cnt, exp_idle);
          wait_first <= 1'b0;
        end
      end
      if (m_axis_tvalid) begin
        if (exq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got tvalid=1 expected no beat");
        end else begin
          chk("grant_tready", {s_axis_ctrl_tready, s_axis_data_tready},
              exq[0].src ? {1'b0, m_axis_tready} : {m_axis_tready, 1'b0});
          if (m_axis_tready) begin
            chk("tdata", m_axis_tdata, exq[0].data);
            chk("tkeep", m_axis_tkeep, exq[0].keep);
            chk("tuser", m_axis_tuser, exq[0].user);
            chk("tlast", m_axis_tlast, exq[0].last);
            if (exq[0].last) begin
              wait_first <= gap_chk_en && (exq.size() > 1);
              idle_cnt   <= 0;
`ifdef MENSHEN_CFG_GAP_EN
              exp_idle   <= exq[0].src ? 1 : GAP + 1;
`else
              exp_idle   <= 1;
`endif
            end
            void'(exq.pop_front());
          end
        end
      end
    end
  end

  task automatic drain(input string nm, input int budget);
    int i = 0;
    while (exq.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_chk++;
    if (exq.size() > 0) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d beats left, expected 0",
               nm, exq.size());
      exq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    cq.delete();
    dq.delete();
    exq.delete();
    aresetn = 1'b1;
  endtask

  // Burst-rule model: both sources hold packets continuously
  task automatic order_model(input int clen[$], input int dlen[$]);
    int ci = 0, di = 0, cp = 0, dp = 0, burst = 0;
    while (ci < clen.size() || di < dlen.size()) begin
      if (ci < clen.size() && (burst < MAXB || di >= dlen.size())) begin
        for (int k = 0; k < clen[ci]; k++) exq.push_back(cq[cp + k]);
        cp += clen[ci];
        ci++;
        if (burst < MAXB) burst++;
      end else begin
        for (int k = 0; k < dlen[di]; k++) exq.push_back(dq[dp + k]);
        dp += dlen[di];
        di++;
        burst = 0;
      end
    end
  endtask

  initial begin
    int   clen[$];
    int   dlen[$];
    int   n;
    bit   found;
    logic [DW-1:0] b2;

    aresetn = 1'b0;
    tmode   = 2;

    // Reset state, held and after release with no traffic
    repeat (2) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_treadys", {s_axis_ctrl_tready, s_axis_data_tready}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cfg_pkt_cnt, 16'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tvalid", m_axis_tvalid, 1'b0);
    chk("idle_treadys", {s_axis_ctrl_tready, s_axis_data_tready}, 2'b00);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt", cfg_pkt_cnt, 16'd0);

    // Data packet in flight when a config packet arrives; toggled ready
    do_reset();
    tmode      = 1;
    nobub      = 1'b0;
    gap_chk_en = 1'b1;
    @(negedge clk);
    #2;
    gen_pkt(1'b1, 3, 1'b1);
    n = 0;
    while (exq.size() > 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("midflight_first_beat", exq.size(), 2);
    gen_pkt(1'b0, 2, 1'b1);
    drain("midflight_drain", 500);
    repeat (2) @(negedge clk);
    chk("midflight_cnt", cfg_pkt_cnt, 16'd1);

    // Both sources loaded, random ready and mid-packet bubbles
    do_reset();
    tmode = 0;
    @(negedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      clen.push_back(int'($urandom_range(1, 4)));
      gen_pkt(1'b0, clen[i], 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      dlen.push_back(int'($urandom_range(1, 4)));
      gen_pkt(1'b1, dlen[i], 1'b0);
    end
    order_model(clen, dlen);
    drain("burst_drain", 20000);
    repeat (2) @(negedge clk);
    chk("burst_cnt", cfg_pkt_cnt, 16'd10);
    chk("burst_busy_end", busy, 1'b0);

    // Reset asserted while beat 2 of a 4-beat config packet is on the bus
    do_reset();
    gap_chk_en = 1'b0;
    mon_en     = 1'b0;
    nobub      = 1'b1;
    tmode      = 2;
    @(negedge clk);
    #2;
    gen_pkt(1'b0, 4, 1'b0);
    b2    = cq[1].data;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == b2) found = 1'b1;
    end
    chk("rst_mid_reach_beat2", found, 1'b1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid_tdata", m_axis_tdata, '0);
    chk("rst_mid_tlast", m_axis_tlast, 1'b0);
    chk("rst_mid_treadys", {s_axis_ctrl_tready, s_axis_data_tready}, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    cq.delete();
    dq.delete();
    exq.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_cnt", cfg_pkt_cnt, 16'd0);
    mon_en = 1'b1;
    #2;
    gen_pkt(1'b0, 1, 1'b1);
    drain("post_rst_drain", 200);
    repeat (2) @(negedge clk);
    chk("post_rst_pkt_cnt", cfg_pkt_cnt, 16'd1);

    repeat (GAP + 5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
